// File: rtl/alu_mdu_if.sv
// Operation request/response bundle between the EX-stage controller and alu_mdu.
// A request (start/op/a/b) is taken on a rising edge only when busy is low; done marks result/zero/hi/lo valid.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic [1:0]       fsm_state;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, hi, lo, div_by_zero, fsm_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, hi, lo, div_by_zero, fsm_state
    );
endinterface

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with iterative shift-add multiply and restoring divide into HI/LO.
// Both iterative ops share one 2*WIDTH working register: {acc, multiplier} or {remainder, quotient}.
module alu_mdu #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic      clk,
    input logic      reset,
    alu_mdu_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = W / K;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] prod, prod_nx, prod_fix;
    logic [W-1:0]   opnd;
    logic           neg_q, neg_r, dbz_pend;
    logic [W-1:0]   result_q, hi_q, lo_q;
    logic           zero_q, dbz_q;

    logic           busy, accept, last, is_mul, is_div, sgn;
    logic [W-1:0]   mag_a, mag_b, alu_res, hi_f, lo_f;
    logic [W+K-1:0] sum;
    logic [W:0]     rem_t;

    assign busy   = (state == MUL) || (state == DIV);
    assign accept = bus.start && !busy;
    assign last   = busy && (cnt == CW'(1));
    assign is_mul = (bus.op[3:1] == 3'b100);
    assign is_div = (bus.op[3:1] == 3'b101);
    assign sgn    = (is_mul || is_div) && !bus.op[0];
    assign mag_a  = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
    assign mag_b  = (sgn && bus.b[W-1]) ? -bus.b : bus.b;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'b0000: alu_res = bus.a & bus.b;
            4'b0001: alu_res = bus.a | bus.b;
            4'b0010: alu_res = bus.a + bus.b;
            4'b0110: alu_res = bus.a - bus.b;
            4'b0111: alu_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b1100: alu_res = ~(bus.a | bus.b);
            4'b1101: alu_res = hi_q;
            4'b1110: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // One radix-2^K multiply step, or K radix-2 restoring divide steps, per edge.
    always_comb begin
        prod_nx = prod;
        rem_t   = '0;
        sum     = '0;
        if (state == MUL) begin
            sum = {{K{1'b0}}, prod[2*W-1:W]} + ({{K{1'b0}}, opnd} * {{W{1'b0}}, prod[K-1:0]});
            prod_nx = prod >> K;
            prod_nx[2*W-1 -: W+K] = sum;
        end else if (state == DIV) begin
            for (int i = 0; i < K; i++) begin
                rem_t   = prod_nx[2*W-1:W-1];
                prod_nx = prod_nx << 1;
                if (rem_t >= {1'b0, opnd}) begin
                    rem_t      = rem_t - {1'b0, opnd};
                    prod_nx[0] = 1'b1;
                end
                prod_nx[2*W-1:W] = rem_t[W-1:0];
            end
        end
    end

    // Sign fix-up on the final iteration's value so hi/lo are already valid in FIN.
    always_comb begin
        prod_fix = neg_q ? -prod_nx : prod_nx;
        hi_f     = prod_fix[2*W-1:W];
        lo_f     = prod_fix[W-1:0];
        if (state == DIV) begin
            lo_f = dbz_pend ? '1 : (neg_q ? -prod_nx[W-1:0] : prod_nx[W-1:0]);
            hi_f = neg_r ? -prod_nx[2*W-1:W] : prod_nx[2*W-1:W];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: begin
                if (!bus.start)  state_nx = IDLE;
                else if (is_mul) state_nx = MUL;
                else if (is_div) state_nx = DIV;
                else             state_nx = FIN;
            end
            MUL, DIV: if (last) state_nx = FIN;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            prod     <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            dbz_q <= 1'b0;
            if (is_mul || is_div) begin
                cnt      <= CW'(N);
                neg_q    <= sgn && (bus.a[W-1] ^ bus.b[W-1]);
                neg_r    <= sgn && bus.a[W-1];
                dbz_pend <= is_div && (bus.b == '0);
                opnd     <= is_mul ? mag_a : mag_b;
                prod     <= {{W{1'b0}}, (is_mul ? mag_b : mag_a)};
            end else begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
            end
        end else if (busy) begin
            prod <= prod_nx;
            cnt  <= cnt - 1'b1;
            if (last) begin
                hi_q     <= hi_f;
                lo_q     <= lo_f;
                result_q <= lo_f;
                zero_q   <= (lo_f == '0);
                dbz_q    <= dbz_pend;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = (state == FIN);
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32, one bit per iteration): vector table plus multi-cycle corner sequences.
module tb_alu_mdu;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MFHI = 4'b1101, OP_MFLO = 4'b1110;
  localparam logic [3:0] OP_MULT = 4'b1000, OP_MULTU = 4'b1001, OP_DIV = 4'b1010, OP_DIVU = 4'b1011;
  localparam int NV = 20;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[NV];

  alu_mdu_if #(.WIDTH(32)) bus();

  alu_mdu #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Called at a negedge; drives the request for one edge, returns at the negedge where done is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 1;
    busy_n    = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busy_n, done_n;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{OP_ADD,   32'd2,        32'd3,        32'd5,        1'b0, 32'h0,        32'h0,        1'b0, 1};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[2]  = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1};
    vecs[3]  = '{OP_MFLO,  32'h0,        32'h0,        32'hFFFFFFF1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1};
    vecs[4]  = '{OP_MULTU, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 32'h4,        32'hFFFFFFF1, 1'b0, 33};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 32'd2,        32'd14,       1'b0, 33};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h0,        32'h80000000, 1'b0, 33};
    vecs[8]  = '{OP_DIV,   32'h1234,     32'h0,        32'hFFFFFFFF, 1'b0, 32'h1234,     32'hFFFFFFFF, 1'b1, 33};
    vecs[9]  = '{OP_AND,   32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[10] = '{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[11] = '{OP_SUB,   32'd7,        32'd7,        32'd0,        1'b1, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[12] = '{OP_OR,    32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[13] = '{OP_NOR,   32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[14] = '{OP_ADD,   32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[15] = '{OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[16] = '{4'b0011,  32'd5,        32'd6,        32'd0,        1'b1, 32'h1234,     32'hFFFFFFFF, 1'b0, 1};
    vecs[17] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFE, 32'h1,        1'b0, 33};
    vecs[18] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'h1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[19] = '{OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 32'h1,        32'hFFFFFFFD, 1'b0, 1};

    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset zero", {31'b0, bus.zero}, 32'd1);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset state", {30'b0, bus.fsm_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy cycles", i), busy_n, vecs[i].lat - 1);
      check($sformatf("v%0d result", i), bus.result, vecs[i].res);
      check($sformatf("v%0d zero", i), {31'b0, bus.zero}, {31'b0, vecs[i].z});
      check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d div_by_zero", i), {31'b0, bus.div_by_zero}, {31'b0, vecs[i].dbz});
      check($sformatf("v%0d busy at done", i), {31'b0, bus.busy}, 32'd0);
    end

    // A start pulsed mid-divide must be dropped without disturbing the divide.
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
    check("ignored start latency", lat, 33);
    check("ignored start lo", bus.lo, 32'd14);
    check("ignored start hi", bus.hi, 32'd2);
    check("ignored start result", bus.result, 32'd14);
    @(negedge clk);
    check("no extra done after divide", {31'b0, bus.done}, 32'd0);

    // MFLO issued in the FIN cycle must see the freshly written lo.
    run_op(OP_MULT, 32'd3, 32'd4, lat, busy_n);
    check("fin mult lo", bus.lo, 32'd12);
    check("fin mult hi", bus.hi, 32'd0);
    run_op(OP_MFLO, 32'd0, 32'd0, lat, busy_n);
    check("fin mflo latency", lat, 1);
    check("fin mflo result", bus.result, 32'd12);

    // Reset at cycle 10 of a MULT aborts it with no done pulse.
    run_op(OP_DIVU, 32'd99, 32'd10, lat, busy_n);
    check("pre-reset lo", bus.lo, 32'd9);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy at cycle 10", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort done", {31'b0, bus.done}, 32'd0);
    check("abort result", bus.result, 32'd0);
    check("abort zero", {31'b0, bus.zero}, 32'd1);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    check("abort state", {30'b0, bus.fsm_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("done pulses after abort", done_n, 0);
    run_op(OP_ADD, 32'd2, 32'd3, lat, busy_n);
    check("post-reset add latency", lat, 1);
    check("post-reset add result", bus.result, 32'd5);
    check("post-reset add zero", {31'b0, bus.zero}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
